// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants: FIPS-197 forward and inverse S-boxes
// plus the single-byte lookup helper used by every lane.
package aes_pkg;

  localparam int AES_BYTE_W = 8;

  localparam logic [AES_BYTE_W-1:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [AES_BYTE_W-1:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [AES_BYTE_W-1:0] sub_byte(input logic [AES_BYTE_W-1:0] b,
                                                     input logic inv);
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// One combinational S-box lane. With AES_SUBBYTES_INV_EN defined the mode bit picks
// forward/inverse; otherwise the lane is forward-only and the inverse table folds away.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] value,
  input  logic                  inv,
  output logic [AES_BYTE_W-1:0] result
);

`ifdef AES_SUBBYTES_INV_EN
  assign result = sub_byte(value, inv);
`else
  // Encrypt-only build: the mode bit still travels with the beat but never reaches a table.
  logic unused_inv;
  assign unused_inv = inv;
  assign result     = sub_byte(value, 1'b0);
`endif

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Multi-lane, registered AES SubBytes/InvSubBytes engine with valid/ready on both sides.
// Inverse support is selected at build time by AES_SUBBYTES_INV_EN (handled per lane).
module aes_subbytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_inv,
  input  logic [AES_BYTE_W*LANES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_inv,
  output logic [AES_BYTE_W*LANES-1:0] out_data,
  output logic [CNT_W-1:0]            beat_cnt,
  output logic                        busy
);

  localparam int                DATA_W  = AES_BYTE_W * LANES;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_inv;
  logic [DATA_W-1:0] stage_data [STAGES];
  logic [DATA_W-1:0] sub_data;
  logic              stall;
  logic              accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_byte u_sbox (
      .value  (in_data[i*AES_BYTE_W +: AES_BYTE_W]),
      .inv    (in_inv),
      .result (sub_data[i*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  // A single global stall freezes the whole pipe; bubbles are never squeezed out.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // Payload only moves alongside a valid bit, so idle-cycle X on the inputs never lands in a stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      stage_inv   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_data[k] <= '0;
      end
    end else if (!stall) begin
      stage_valid[0] <= accept;
      if (accept) begin
        stage_inv[0]  <= in_inv;
        stage_data[0] <= sub_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        if (stage_valid[k-1]) begin
          stage_inv[k]  <= stage_inv[k-1];
          stage_data[k] <= stage_data[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (accept && (beat_cnt != CNT_MAX)) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_inv   = stage_inv[STAGES-1];
  assign out_data  = stage_data[STAGES-1];
  assign busy      = |stage_valid;

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Self-checking bench: a 16-lane 3-stage pipe against a GF(2^8)-derived S-box model,
// plus a 1-lane 1-stage pipe with a 4-bit counter for single-cycle latency and saturation.
module tb_aes_subbytes_pipe;

  localparam int LANES   = 16;
  localparam int STAGES  = 3;
  localparam int DW      = 8 * LANES;
  localparam int CNT_SAT = 65535;
  localparam int B_SAT   = 15;

  typedef struct {
    logic [DW-1:0] data;
    logic          inv;
    int            tick;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_inv;
  logic          out_valid, out_ready, out_inv, busy;
  logic [DW-1:0] in_data, out_data;
  logic [15:0]   beat_cnt;

  logic          b_in_valid, b_in_ready, b_in_inv;
  logic          b_out_valid, b_out_ready, b_out_inv, b_busy;
  logic [7:0]    b_in_data, b_out_data;
  logic [3:0]    b_beat_cnt;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];
  beat_t      exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         tick_no = 0;
  int         accepted = 0;
  bit         check_latency = 1'b1;

  always #5 clk = ~clk;

  aes_subbytes_pipe #(.LANES(LANES), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data),
    .beat_cnt(beat_cnt), .busy(busy)
  );

  aes_subbytes_pipe #(.LANES(1), .STAGES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inv(b_out_inv), .out_data(b_out_data),
    .beat_cnt(b_beat_cnt), .busy(b_busy)
  );

  // Reference S-box built from the field inverse and affine map, not from a table.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inverse(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(a, y[7:0]) == 8'h01) r = y[7:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic void build_tables();
    logic [7:0] v;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      v = gf_inverse(x[7:0]);
      s = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
      ref_fwd[x]  = s;
      ref_inv[s]  = x[7:0];
    end
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] b, input logic inv);
`ifdef AES_SUBBYTES_INV_EN
    return inv ? ref_inv[b] : ref_fwd[b];
`else
    logic unused_mode;
    unused_mode = inv;
    return ref_fwd[b];
`endif
  endfunction

  function automatic logic [DW-1:0] model_vec(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = model_byte(d[8*i +: 8], inv);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [DW-1:0] data, input logic inv);
    in_valid = valid;
    in_data  = data;
    in_inv   = inv;
  endtask

  // One main-pipe cycle: score the handshakes that will fire on the coming edge, then advance.
  task automatic tick();
    beat_t e;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_output("out_data", out_data, e.data);
        check_output("out_inv", out_inv, e.inv);
        if (check_latency) check_output("latency", tick_no - e.tick, STAGES);
      end
    end
    if (in_valid && in_ready) begin
      e.data = model_vec(in_data, in_inv);
      e.inv  = in_inv;
      e.tick = tick_no;
      exp_q.push_back(e);
      accepted++;
    end
    @(posedge clk);
    @(negedge clk);
    tick_no++;
  endtask

  task automatic wait_out_valid(input int limit);
    int n;
    n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
    check_output("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    apply_stimulus(1'b0, 'x, 1'bx);
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < limit) begin
      tick();
      n++;
    end
    check_output("drain", exp_q.size(), 0);
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] held_data;
    logic          held_inv;
    logic [7:0]    bb;
    logic [7:0]    bd;
    logic          bi;
    int            b_acc;

    build_tables();
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0);
    b_in_valid  = 1'b0;
    b_in_data   = 8'h00;
    b_in_inv    = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_out_data", out_data, '0);
    check_output("rst_out_inv", out_inv, 1'b0);
    check_output("rst_beat_cnt", beat_cnt, 16'd0);
    check_output("rst_b_out_valid", b_out_valid, 1'b0);
    check_output("rst_b_beat_cnt", b_beat_cnt, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("in_ready_after_rst", in_ready, 1'b1);

    $display("[TB] single forward beat");
    apply_stimulus(1'b1, {120'h0, 8'h53}, 1'b0);
    tick();
    apply_stimulus(1'b0, 'x, 1'bx);
    wait_out_valid(10);
    check_output("fwd_lane0", out_data[7:0], 8'hed);
    check_output("fwd_lane1", out_data[15:8], 8'h63);
    check_output("fwd_cnt", beat_cnt, 16'd1);
    tick();

    $display("[TB] inverse-mode beat");
    apply_stimulus(1'b1, {104'h0, 8'hff, 8'h00, 8'h63}, 1'b1);
    tick();
    apply_stimulus(1'b0, 'x, 1'bx);
    wait_out_valid(10);
`ifdef AES_SUBBYTES_INV_EN
    check_output("inv_lanes", out_data[23:0], 24'h7d5200);
`else
    check_output("inv_lanes", out_data[23:0], 24'h1663fb);
`endif
    check_output("inv_out_inv", out_inv, 1'b1);
    tick();
    drain(10);

    $display("[TB] full-throughput stream");
    for (int b = 0; b < 256; b++) begin
      bb = b[7:0];
      apply_stimulus(1'b1, {LANES{bb}}, bb[0]);
      tick();
    end
    drain(20);
    check_output("stream_cnt", beat_cnt, sat(accepted, CNT_SAT));

    $display("[TB] backpressure hold");
    check_latency = 1'b0;
    out_ready = 1'b0;
    for (int n = 0; n < 10 && in_ready; n++) begin
      apply_stimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      tick();
    end
    check_output("bp_in_ready", in_ready, 1'b0);
    held_data = out_data;
    held_inv  = out_inv;
    for (int n = 0; n < 5; n++) begin
      apply_stimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      tick();
      check_output("bp_hold_ready", in_ready, 1'b0);
      check_output("bp_hold_data", out_data, held_data);
      check_output("bp_hold_inv", out_inv, held_inv);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      apply_stimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      tick();
    end
    drain(20);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0)
        apply_stimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      else
        apply_stimulus(1'b0, 'x, 1'bx);
      tick();
    end
    drain(30);
    check_output("random_cnt", beat_cnt, sat(accepted, CNT_SAT));

    $display("[TB] reset with beats in flight");
    check_latency = 1'b1;
    for (int n = 0; n < 2; n++) begin
      apply_stimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 'x, 1'bx);
    check_output("inflight_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_out_valid", out_valid, 1'b0);
    check_output("async_busy", busy, 1'b0);
    check_output("async_cnt", beat_cnt, 16'd0);
    exp_q.delete();
    accepted = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("post_rst_ready", in_ready, 1'b1);
    apply_stimulus(1'b1, {LANES{8'h01}}, 1'b0);
    tick();
    apply_stimulus(1'b0, 'x, 1'bx);
    wait_out_valid(10);
    check_output("post_rst_lane0", out_data[7:0], 8'h7c);
    check_output("post_rst_cnt", beat_cnt, 16'd1);
    drain(10);

    $display("[TB] single-stage pipe and counter saturation");
    b_in_valid = 1'b1;
    b_in_data  = 8'h53;
    b_in_inv   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_data  = 'x;
    b_in_inv   = 1'bx;
    check_output("b_latency_valid", b_out_valid, 1'b1);
    check_output("b_data", b_out_data, 8'hed);
    check_output("b_cnt1", b_beat_cnt, 4'd1);
    @(negedge clk);
    check_output("b_consumed", b_out_valid, 1'b0);
    check_output("b_idle_busy", b_busy, 1'b0);
    b_acc = 1;
    for (int n = 0; n < 20; n++) begin
      bd = 8'($urandom);
      bi = 1'($urandom);
      b_in_valid = 1'b1;
      b_in_data  = bd;
      b_in_inv   = bi;
      @(posedge clk);
      @(negedge clk);
      b_acc++;
      check_output("b_stream_valid", b_out_valid, 1'b1);
      check_output("b_stream_data", b_out_data, model_byte(bd, bi));
      check_output("b_stream_inv", b_out_inv, bi);
      check_output("b_sat_cnt", b_beat_cnt, sat(b_acc, B_SAT));
    end
    b_in_valid = 1'b0;
    b_in_data  = 'x;
    @(negedge clk);
    check_output("b_sat_hold", b_beat_cnt, 4'd15);

    check_output("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_pipe.md
Name: aes_subbytes_pipe

Overview:
Parametrised, pipelined AES SubBytes/InvSubBytes engine.
- Applies the forward or inverse S-box to LANES independent bytes per beat.
- Uses a valid/ready handshake on both input and output.
- Sits between the round-key XOR stage and ShiftRows in the AES datapath (encrypt and decrypt).
- Supersedes the single combinational byte lookup with a multi-lane, registered, mode-selectable unit.

Parameters:
LANES, 16, bytes substituted per beat (legal 1..16); data width is 8*LANES.
STAGES, 1, pipeline register stages from input acceptance to output (legal 1..3).
CNT_W, 16, width of the accepted-beat counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat
in_data  input  8*LANES  bytes to substitute; lane i = in_data[8i+7:8i]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts a beat
out_inv  output  1  mode carried with the beat
out_data  output  8*LANES  substituted bytes, same lane order
beat_cnt  output  CNT_W  number of accepted input beats, saturating
busy  output  1  any pipeline stage holds a valid beat

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, so out_valid=0 and busy=0. out_data=0, out_inv=0, beat_cnt=0. in_ready=1 from the first cycle after release.
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stages: stage k holds {valid, inv, data}. Lookup is combinational on the stage-1 input path; stages 2..STAGES are pure delay.
- Latency: a beat accepted at edge N is visible on out_* after edge N+STAGES-1, i.e. available to downstream STAGES cycles after in_valid is presented. For STAGES=1, output appears the cycle after acceptance.
- Stall (global): stall = out_valid && !out_ready. in_ready = !stall. When stall=1, every stage holds its contents; no bubble compression.
- Advance: when stall=0, every stage advances. Stage 1 loads valid = in_valid && in_ready. A bubble enters when in_valid=0.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_inv must not change.
- Simultaneous accept and consume in the same cycle: full throughput, one beat per cycle, no lost or duplicated beats.
- Mode: in_inv is per beat. Consecutive beats may alternate mode with no penalty.
- Lookup values: forward and inverse lookups follow FIPS-197 exactly. The inverse table maps 00->52, 63->00, ff->7d.
- beat_cnt: increments on each input acceptance and saturates at 2^CNT_W-1; it does not wrap.
- busy: OR of all stage valid bits.
- Reset mid-operation: beats in flight are discarded and are not replayed.
- Data/mode inputs are don't-care while in_valid=0. X on in_data with in_valid=0 must not propagate to out_data while out_valid=1.

Optional Feature:
Macro AES_SUBBYTES_INV_EN.
- Defined: the inverse table is compiled in and in_inv selects the mode per beat.
- Undefined: the inverse tables are not built, in_inv is ignored, and every beat uses the forward S-box. out_inv is still the carried in_inv value so the output port is always present. Saves LANES inverse lookups of area for encrypt-only builds.

Decomposition:
- Package aes_pkg:
  - 256-entry forward S-box constant array and 256-entry inverse S-box constant array.
  - function sub_byte(byte, inv).
  - localparam AES_BYTE_W=8.
- Sub-module aes_sbox_byte: one combinational lane with inputs byte and inv, output byte. Instantiated LANES times via generate. Honours AES_SUBBYTES_INV_EN internally.
- Pipeline/handshake logic stays in aes_subbytes_pipe.

Test Plan:
- Reset then single beat, LANES=16, STAGES=1, in_inv=0, in_data all lanes 0x00 except lane0=0x53 -> out_valid one cycle after acceptance; lane0=0xed, other lanes 0x63; beat_cnt=1.
- Inverse beat, in_inv=1: lane0=0x63, lane1=0x00, lane2=0xff -> out lanes 0x00, 0x52, 0x7d; out_inv=1. With the macro undefined, the same stimulus gives 0xfb, 0x63, 0x16.
- Full-throughput stream, STAGES=3: 256 back-to-back beats where lane i = beat index, mode alternating, out_ready=1 -> first output 3 cycles after first acceptance; one output per cycle in order; each byte matches the reference model; beat_cnt=256.
- Backpressure, STAGES=2: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_data stable. On release, no beat is lost or duplicated and order is preserved.
- Reset asserted mid-stream with 2 beats in flight -> out_valid=0 and busy=0 immediately (async), beat_cnt=0. After release, a new beat 0x01 (forward) -> 0x7c.
- CNT_W=4: 20 accepted beats -> beat_cnt saturates at 15 and holds.
